regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Sequencer and arbiter for the 32x32 register file write port. After reset it sweeps every register to its index value, then shares the single write port among `N_REQ` writeback requesters (ALU, load unit, CSR path) with round-robin fairness. It sits between the execute/memory writeback sources and the register file write inputs (write enable, write address, write data).

## Interface
Parameters:
- `N_REQ`, 3, number of writeback requesters (2..8)
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width; register count is 2^ADDR_W

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_init_req`  in  1  pulse: restart the initialisation sweep
- `i_req`  in  N_REQ  per-requester write request; held until granted
- `i_req_addr`  in  N_REQ*ADDR_W  packed target addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- `i_req_data`  in  N_REQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W]
- `o_grant`  out  N_REQ  one-hot or zero; combinational accept for the current cycle
- `o_WriteEn`  out  1  registered write enable to the register file
- `o_WriteAddress`  out  ADDR_W  registered write address
- `o_WriteData`  out  DATA_W  registered write data
- `o_init_busy`  out  1  high while the sweep is running

## Operation
- States: INIT, RUN.
- Reset: enter INIT with sweep counter = 0.
- Reset values: `o_WriteEn`=0, `o_WriteAddress`=0, `o_WriteData`=0, `o_grant`=0, `o_init_busy`=1, RR pointer=0.
- INIT:
  - Each cycle, register `o_WriteEn`=1, `o_WriteAddress`=cnt, and `o_WriteData`=cnt zero-extended to DATA_W.
  - cnt increments by 1. After the write of cnt = 2^ADDR_W-1 is issued, go to RUN. cnt does not wrap.
  - `o_grant` is forced to 0; requests stay pending.
- RUN:
  - `o_grant` selects one asserted `i_req`: the first set bit searching from the RR pointer upward, wrapping modulo N_REQ.
  - A transfer occurs at an edge where `i_req[i] & o_grant[i]`. On that edge, register requester i's address and data into the outputs with `o_WriteEn`=1, and set the RR pointer to (i+1) mod N_REQ.
  - With no request, register `o_WriteEn`=0. Address and data hold their last values.
- `i_init_req` high at an edge in RUN:
  - Enter INIT with cnt = 0. No grant is issued in that cycle, so `o_grant` is masked combinationally while `i_init_req`=1.
  - A write already registered still completes.
- `i_init_req` during INIT restarts cnt at 0.
- Writes to address 0 are forwarded unchanged; the block does not special-case them.
- The RR pointer is not changed by INIT.

## Timing
- Sweep length: exactly 2^ADDR_W consecutive `o_WriteEn` cycles.
  - The first sweep write is visible in the first cycle after reset release.
  - `o_init_busy` falls in the same cycle the last sweep write is on the outputs... no, in the cycle after, i.e. together with the first cycle in which `o_grant` may be nonzero.
- Grant is combinational from `i_req`, state, pointer and `i_init_req`. A requester may therefore drop or change its request in the cycle after the accept edge.
- Write latency: accept at edge E. Outputs carry the write during the cycle after E. The register file captures it at edge E+1.
- Throughput: one accepted write per cycle in RUN, back-to-back, with no bubbles.
- Simultaneous requests: exactly one is accepted per cycle. A continuously asserted request waits at most N_REQ-1 cycles.
- Asynchronous reset mid-write: outputs go to their reset values immediately. The pending write is lost and the sweep restarts.

## Test plan
- Reset release with no requests: 32 cycles of WE=1, addr/data 0,1,...,31. `o_init_busy` falls after address 31. WE=0 afterwards.
- Requests asserted during INIT (i_req=3'b011): no grant until RUN. Then requester 0 is granted first and requester 1 in the next cycle. Outputs follow with 1-cycle latency.
- All three requesters held continuously, with addresses 5/6/7 and data A/B/C: grants cycle 0,1,2,0,... and the write stream is 5:A, 6:B, 7:C, 5:A.
- Pointer fairness: after a grant to requester 2, assert i_req=3'b101. Requester 0 is granted (wrap), then 2.
- `i_init_req` pulse while i_req[1]=1: no grant in that cycle. A 32-write sweep follows, then requester 1 is granted.
- Assert `i_rst_n` low mid-sweep at cnt=10: outputs drop to 0 asynchronously. After release the sweep restarts at address 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Drives the single write port of the register file. After reset, or on an
//   init request, it sweeps every register to its own index value. After the
//   sweep it shares the port among N_REQ writeback requesters with
//   round-robin fairness.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_init_req       pulse: restart the initialisation sweep
//   i_req            per-requester write request, held until granted
//   i_req_addr       packed target addresses, requester i at [i*ADDR_W +: ADDR_W]
//   i_req_data       packed write data, requester i at [i*DATA_W +: DATA_W]
//   o_grant          combinational one-hot (or zero) accept for this cycle
//   o_WriteEn        registered write enable to the register file
//   o_WriteAddress   registered write address
//   o_WriteData      registered write data
//   o_init_busy      high while the sweep is running
module regfile_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_init_req,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*ADDR_W-1:0]  i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]  i_req_data,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_WriteEn,
  output logic [ADDR_W-1:0]        o_WriteAddress,
  output logic [DATA_W-1:0]        o_WriteData,
  output logic                     o_init_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One past the last register index. The counter is one bit wider so that
  // reaching this value marks "sweep issued" without wrapping back to 0.
  localparam logic [ADDR_W:0]  SWEEP_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   N_REQ_W   = (PTR_W + 1)'(N_REQ);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_r,     stateNext_s;
  logic [ADDR_W:0]     sweepCnt_r,  sweepCntNext_s;
  logic [PTR_W-1:0]    rrPtr_r,     rrPtrNext_s;
  logic                writeEn_r,   writeEnNext_s;
  logic [ADDR_W-1:0]   writeAddr_r, writeAddrNext_s;
  logic [DATA_W-1:0]   writeData_r, writeDataNext_s;
  logic                busy_r;

  logic [N_REQ-1:0]    grant_s;
  logic [PTR_W-1:0]    grantIdx_s;
  logic [PTR_W:0]      scanSum_s;
  logic [PTR_W-1:0]    scanIdx_s;
  logic                scanHit_s;

  // Round-robin search: first asserted request at or above the pointer,
  // wrapping modulo N_REQ. Masked outside RUN and while an init is requested.
  always_comb begin
    grant_s    = '0;
    grantIdx_s = '0;
    scanSum_s  = '0;
    scanIdx_s  = '0;
    scanHit_s  = 1'b0;
    if ((state_r == RUN) && !i_init_req) begin
      for (int k = 0; k < N_REQ; k++) begin
        scanSum_s = {1'b0, rrPtr_r} + (PTR_W + 1)'(k);
        if (scanSum_s >= N_REQ_W) begin
          scanSum_s = scanSum_s - N_REQ_W;
        end else begin
          scanSum_s = scanSum_s;
        end
        scanIdx_s = scanSum_s[PTR_W-1:0];
        if (!scanHit_s && i_req[scanIdx_s]) begin
          scanHit_s           = 1'b1;
          grant_s[scanIdx_s]  = 1'b1;
          grantIdx_s          = scanIdx_s;
        end else begin
          scanHit_s = scanHit_s;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  // Next-state, sweep counter, pointer and write-port values.
  always_comb begin
    stateNext_s     = state_r;
    sweepCntNext_s  = sweepCnt_r;
    rrPtrNext_s     = rrPtr_r;
    writeEnNext_s   = 1'b0;
    writeAddrNext_s = writeAddr_r;
    writeDataNext_s = writeData_r;
    if (i_init_req) begin
      // Restart the sweep; the pointer is deliberately left untouched.
      stateNext_s    = INIT;
      sweepCntNext_s = '0;
    end else begin
      case (state_r)
        INIT: begin
          if (sweepCnt_r == SWEEP_END) begin
            // Last sweep write is on the outputs this cycle; hand over next.
            stateNext_s = RUN;
          end else begin
            writeEnNext_s   = 1'b1;
            writeAddrNext_s = sweepCnt_r[ADDR_W-1:0];
            writeDataNext_s = DATA_W'(sweepCnt_r[ADDR_W-1:0]);
            sweepCntNext_s  = sweepCnt_r + (ADDR_W + 1)'(1);
          end
        end
        RUN: begin
          if (|grant_s) begin
            writeEnNext_s   = 1'b1;
            writeAddrNext_s = i_req_addr[grantIdx_s*ADDR_W +: ADDR_W];
            writeDataNext_s = i_req_data[grantIdx_s*DATA_W +: DATA_W];
            rrPtrNext_s     = (grantIdx_s == LAST_REQ) ? '0 : grantIdx_s + PTR_W'(1);
          end else begin
            writeEnNext_s = 1'b0;
          end
        end
        default: begin
          stateNext_s    = INIT;
          sweepCntNext_s = '0;
        end
      endcase
    end
  end

  // State and output registers; reset discards any pending write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= INIT;
      sweepCnt_r  <= '0;
      rrPtr_r     <= '0;
      writeEn_r   <= 1'b0;
      writeAddr_r <= '0;
      writeData_r <= '0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= stateNext_s;
      sweepCnt_r  <= sweepCntNext_s;
      rrPtr_r     <= rrPtrNext_s;
      writeEn_r   <= writeEnNext_s;
      writeAddr_r <= writeAddrNext_s;
      writeData_r <= writeDataNext_s;
      busy_r      <= (stateNext_s == INIT);
    end
  end

  assign o_grant        = grant_s;
  assign o_WriteEn      = writeEn_r;
  assign o_WriteAddress = writeAddr_r;
  assign o_WriteData    = writeData_r;
  assign o_init_busy    = busy_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   cycle-level behavioural model of the sweep / round-robin rules.
module tb_regfile_write_arbiter;

  localparam int N    = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            initReq;
  logic [N-1:0]    req;
  logic [AW-1:0]   rAddr [N];
  logic [DW-1:0]   rData [N];
  logic [N*AW-1:0] reqAddrBus;
  logic [N*DW-1:0] reqDataBus;
  logic [N-1:0]    grant;
  logic            writeEn;
  logic [AW-1:0]   writeAddr;
  logic [DW-1:0]   writeData;
  logic            initBusy;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign reqAddrBus[gi*AW +: AW] = rAddr[gi];
    assign reqDataBus[gi*DW +: DW] = rData[gi];
  end

  regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_req(initReq), .i_req(req),
    .i_req_addr(reqAddrBus), .i_req_data(reqDataBus), .o_grant(grant),
    .o_WriteEn(writeEn), .o_WriteAddress(writeAddr), .o_WriteData(writeData),
    .o_init_busy(initBusy)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model
  bit            mInit;
  int            mCnt;
  int            mPtr;
  bit            mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  int            lastPick;

  task automatic modelReset();
    mInit = 1'b1; mCnt = 0; mPtr = 0; mWe = 1'b0; mAddr = '0; mData = '0; lastPick = -1;
  endtask

  function automatic int pick();
    if (mInit || initReq) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mPtr + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] expG();
    logic [N-1:0] v;
    int g;
    v = '0;
    g = pick();
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Called just after a falling edge with inputs set; advances one clock.
  task automatic tick();
    int g;
    g = pick();
    @(posedge clk);
    if (initReq) begin
      mInit = 1'b1; mCnt = 0; mWe = 1'b0;
    end else if (mInit) begin
      if (mCnt == NREG) begin
        mInit = 1'b0; mWe = 1'b0;
      end else begin
        mWe = 1'b1; mAddr = AW'(mCnt); mData = DW'(mCnt); mCnt++;
      end
    end else if (g >= 0) begin
      mWe = 1'b1; mAddr = rAddr[g]; mData = rData[g]; mPtr = (g + 1) % N;
    end else begin
      mWe = 1'b0;
    end
    lastPick = g;
    @(negedge clk);
  endtask

  task automatic test_reset();
    initReq = 1'b0; req = '1; rst_n = 1'b0; modelReset();
    for (int i = 0; i < N; i++) begin rAddr[i] = '0; rData[i] = '0; end
    @(negedge clk); #1;
    checks++;
    if (writeEn !== 1'b0 || writeAddr !== '0 || writeData !== '0 || initBusy !== 1'b1 || grant !== '0) begin
      errors++;
      $display("FAIL reset_values we=%b addr=%0d data=%0h busy=%b grant=%b exp 0 0 0 1 000",
               writeEn, writeAddr, writeData, initBusy, grant);
    end
    req = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < NREG + 2; k++) begin
      logic          eWe;
      logic [AW-1:0] eA;
      #1;
      checks++;
      if (grant !== '0) begin errors++; $display("FAIL sweep_grant k=%0d got %b exp 000", k, grant); end
      tick();
      eWe = (k < NREG);
      eA  = (k < NREG) ? AW'(k) : AW'(NREG - 1);
      checks++;
      if (writeEn !== eWe || writeAddr !== eA || writeData !== DW'(eA) || initBusy !== eWe) begin
        errors++;
        $display("FAIL sweep_write k=%0d got we=%b a=%0d d=%0h busy=%b exp we=%b a=%0d d=%0h busy=%b",
                 k, writeEn, writeAddr, writeData, initBusy, eWe, eA, eA, eWe);
      end
    end
  endtask

  task automatic test_all_continuous();
    for (int i = 0; i < N; i++) begin rAddr[i] = AW'(5 + i); rData[i] = DW'(32'hA + i); end
    req = '1;
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] eG;
      int e;
      e = c % N;
      eG = '0; eG[e] = 1'b1;
      #1;
      checks++;
      if (grant !== eG) begin errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, grant, eG); end
      tick();
      checks++;
      if (writeEn !== 1'b1 || writeAddr !== AW'(5 + e) || writeData !== DW'(32'hA + e)) begin
        errors++;
        $display("FAIL rr_write c=%0d got we=%b a=%0d d=%0h exp 1 %0d %0h", c, writeEn, writeAddr, writeData, 5 + e, 32'hA + e);
      end
    end
    req = '0;
  endtask

  task automatic test_fairness();
    rAddr[0] = 5'd0;  rData[0] = 32'h1111;
    rAddr[2] = 5'd31; rData[2] = 32'h2222;
    req = 3'b100; #1;
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL fair_g2 got %b exp 100", grant); end
    tick();
    req = 3'b101; #1;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL fair_wrap got %b exp 001", grant); end
    tick();
    checks++;
    if (writeEn !== 1'b1 || writeAddr !== 5'd0 || writeData !== 32'h1111) begin
      errors++; $display("FAIL fair_addr0 got we=%b a=%0d d=%0h exp 1 0 1111", writeEn, writeAddr, writeData);
    end
    req = 3'b100; #1;
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL fair_then2 got %b exp 100", grant); end
    tick();
    req = 3'b000; #1;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL fair_idle_grant got %b exp 000", grant); end
    tick();
    checks++;
    if (writeEn !== 1'b0 || writeAddr !== 5'd31 || writeData !== 32'h2222) begin
      errors++; $display("FAIL fair_hold got we=%b a=%0d d=%0h exp 0 31 2222", writeEn, writeAddr, writeData);
    end
  endtask

  task automatic test_init_pending();
    rst_n = 1'b0; modelReset(); req = 3'b011;
    rAddr[0] = 5'd3; rData[0] = 32'hCAFE0003;
    rAddr[1] = 5'd9; rData[1] = 32'hCAFE0009;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < NREG + 1; k++) begin
      #1;
      checks++; if (grant !== '0) begin errors++; $display("FAIL pend_grant k=%0d got %b exp 000", k, grant); end
      tick();
    end
    #1;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL pend_first got %b exp 001", grant); end
    tick();
    checks++;
    if (writeEn !== 1'b1 || writeAddr !== 5'd3 || writeData !== 32'hCAFE0003) begin
      errors++; $display("FAIL pend_w0 got we=%b a=%0d d=%0h exp 1 3 cafe0003", writeEn, writeAddr, writeData);
    end
    req = 3'b010; #1;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL pend_second got %b exp 010", grant); end
    tick();
    checks++;
    if (writeEn !== 1'b1 || writeAddr !== 5'd9 || writeData !== 32'hCAFE0009) begin
      errors++; $display("FAIL pend_w1 got we=%b a=%0d d=%0h exp 1 9 cafe0009", writeEn, writeAddr, writeData);
    end
    req = '0;
  endtask

  task automatic test_init_req();
    req = 3'b010; rAddr[1] = 5'd12; rData[1] = 32'h5A5A0012;
    initReq = 1'b1; #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL initreq_mask got %b exp 000", grant); end
    tick();
    initReq = 1'b0;
    checks++;
    if (writeEn !== 1'b0 || initBusy !== 1'b1) begin
      errors++; $display("FAIL initreq_enter got we=%b busy=%b exp 0 1", writeEn, initBusy);
    end
    for (int k = 0; k < NREG + 1; k++) begin
      #1;
      checks++; if (grant !== '0) begin errors++; $display("FAIL initreq_grant k=%0d got %b exp 000", k, grant); end
      tick();
      checks++;
      if ({writeEn, writeAddr, writeData, initBusy} !== {mWe, mAddr, mData, mInit}) begin
        errors++;
        $display("FAIL initreq_sweep k=%0d got we=%b a=%0d d=%0h busy=%b exp %b %0d %0h %b",
                 k, writeEn, writeAddr, writeData, initBusy, mWe, mAddr, mData, mInit);
      end
    end
    #1;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL initreq_after got %b exp 010", grant); end
    tick();
    checks++;
    if (writeEn !== 1'b1 || writeAddr !== 5'd12 || writeData !== 32'h5A5A0012) begin
      errors++; $display("FAIL initreq_w1 got we=%b a=%0d d=%0h exp 1 12 5a5a0012", writeEn, writeAddr, writeData);
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0; modelReset(); req = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (writeAddr !== 5'd9 || writeEn !== 1'b1) begin
      errors++; $display("FAIL arst_pre got we=%b a=%0d exp 1 9", writeEn, writeAddr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (writeEn !== 1'b0 || writeAddr !== '0 || writeData !== '0 || initBusy !== 1'b1) begin
      errors++; $display("FAIL arst_drop got we=%b a=%0d d=%0h busy=%b exp 0 0 0 1", writeEn, writeAddr, writeData, initBusy);
    end
    modelReset();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (writeEn !== 1'b1 || writeAddr !== AW'(k) || writeData !== DW'(k)) begin
        errors++; $display("FAIL arst_restart k=%0d got we=%b a=%0d d=%0h exp 1 %0d %0d", k, writeEn, writeAddr, writeData, k, k);
      end
    end
  endtask

  task automatic test_random();
    int waitCnt [N];
    rst_n = 1'b0; modelReset(); req = '0; initReq = 1'b0;
    for (int i = 0; i < N; i++) waitCnt[i] = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom_range(0, 1) == 1)) begin
          req[i] = 1'b1; rAddr[i] = AW'($urandom); rData[i] = $urandom;
        end
      end
      initReq = ($urandom_range(0, 59) == 0);
      #1;
      checks++;
      if (grant !== expG()) begin errors++; $display("FAIL rand_grant c=%0d got %b exp %b", c, grant, expG()); end
      for (int i = 0; i < N; i++) begin
        if (!mInit && !initReq && req[i] && !grant[i]) begin
          waitCnt[i]++;
          checks++;
          if (waitCnt[i] > N - 1) begin
            errors++; $display("FAIL rand_starve c=%0d req=%0d waited %0d exp <= %0d", c, i, waitCnt[i], N - 1);
          end
        end else begin
          waitCnt[i] = 0;
        end
      end
      tick();
      checks++;
      if ({writeEn, writeAddr, writeData, initBusy} !== {mWe, mAddr, mData, mInit}) begin
        errors++;
        $display("FAIL rand_write c=%0d got we=%b a=%0d d=%0h busy=%b exp %b %0d %0h %b",
                 c, writeEn, writeAddr, writeData, initBusy, mWe, mAddr, mData, mInit);
      end
      if (lastPick >= 0) req[lastPick] = 1'b0;
    end
    initReq = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_all_continuous();
    test_fairness();
    test_init_pending();
    test_init_req();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
